// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array slice: legal array sizes, default
// element width and the result drain FSM encoding.
package systolic_pkg;

  localparam int N_MIN     = 3;
  localparam int N_MAX     = 256;
  localparam int DEF_ROW_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  function automatic bit n_legal(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

endpackage

// File: rtl/result_drain_buffer.sv
// Two-slot ping-pong capture of the N x N result matrix, drained one row per
// valid/ready beat, with a sticky flag for results dropped while both slots are full.
module result_drain_buffer
  import systolic_pkg::*;
#(
  parameter int N     = 8,
  parameter int ROW_W = DEF_ROW_W
) (
  input  logic                                i_clk,
  input  logic                                i_arst,
  input  logic signed [N-1:0][N-1:0][ROW_W-1:0] i_c,
  input  logic                                i_validResult,
  output logic                                o_ready,
  output logic signed [N-1:0][ROW_W-1:0]      o_rowData,
  output logic                                o_rowValid,
  input  logic                                i_rowReady,
  output logic [$clog2(N)-1:0]                o_rowIdx,
  output logic                                o_lastRow,
  output logic [1:0]                          o_occupancy,
  output logic                                o_overflow,
  input  logic                                i_clearOverflow
);

  localparam int RIDX_W = $clog2(N);
  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(N - 1);

  typedef logic signed [N-1:0][N-1:0][ROW_W-1:0] result_matrix_t;

  if (!n_legal(N)) begin : g_bad_n
    $error("result_drain_buffer: N=%0d outside legal range %0d..%0d", N, N_MIN, N_MAX);
  end

  result_matrix_t    slot_q [2];
  drain_state_e      state_q,   state_d;
  logic              wr_ptr_q,  wr_ptr_d;
  logic              rd_ptr_q,  rd_ptr_d;
  logic [RIDX_W-1:0] row_cnt_q, row_cnt_d;
  logic [1:0]        occ_q,     occ_d;
  logic              ovf_q,     ovf_d;

  logic row_valid, handshake, final_hs, capture, drop;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    row_cnt_d = row_cnt_q;
    ovf_d     = ovf_q;
    row_valid = 1'b0;

    case (state_q)
      IDLE:    row_valid = 1'b0;
      DRAIN:   row_valid = 1'b1;
      default: row_valid = 1'b0;
    endcase

    handshake = row_valid && i_rowReady;
    final_hs  = handshake && (row_cnt_q == LAST_ROW);
    // A release on the final row frees a slot in time for a same-cycle capture.
    capture   = i_validResult && ((occ_q != 2'd2) || final_hs);
    drop      = i_validResult && !capture;

    if (handshake) row_cnt_d = final_hs ? '0 : row_cnt_q + 1'b1;
    if (final_hs)  rd_ptr_d  = ~rd_ptr_q;
    if (capture)   wr_ptr_d  = ~wr_ptr_q;
    occ_d = occ_q + {1'b0, capture} - {1'b0, final_hs};

    if (drop)                 ovf_d = 1'b1;
    else if (i_clearOverflow) ovf_d = 1'b0;

    // Decided on next occupancy so the first beat follows the capture directly.
    case (state_q)
      IDLE:    if (occ_d != 2'd0) state_d = DRAIN;
      DRAIN:   if (final_hs && (occ_d == 2'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      row_cnt_q <= '0;
      occ_q     <= 2'd0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      row_cnt_q <= row_cnt_d;
      occ_q     <= occ_d;
      ovf_q     <= ovf_d;
    end
  end

  // NOTE: slot storage has no reset; occupancy governs validity and the row
  // output is gated to zero whenever no beat is offered.
  always_ff @(posedge i_clk) begin
    if (capture) slot_q[wr_ptr_q] <= i_c;
  end

  assign o_rowValid  = row_valid;
  assign o_rowData   = row_valid ? slot_q[rd_ptr_q][row_cnt_q] : '0;
  assign o_rowIdx    = row_cnt_q;
  assign o_lastRow   = row_valid && (row_cnt_q == LAST_ROW);
  assign o_occupancy = occ_q;
  assign o_overflow  = ovf_q;
  assign o_ready     = (occ_q != 2'd2);

endmodule

// File: tb/tb_result_drain_buffer.sv
// Self-checking bench for result_drain_buffer (N=4): directed scenarios plus a
// randomized phase, all compared against a queue-of-matrices reference model.
module tb_result_drain_buffer;

  localparam int TN = 4;
  localparam int TW = 32;

  typedef logic signed [TN-1:0][TN-1:0][TW-1:0] mat_t;

  logic                          i_clk;
  logic                          i_arst;
  mat_t                          i_c;
  logic                          i_validResult;
  logic                          o_ready;
  logic signed [TN-1:0][TW-1:0]  o_rowData;
  logic                          o_rowValid;
  logic                          i_rowReady;
  logic [1:0]                    o_rowIdx;
  logic                          o_lastRow;
  logic [1:0]                    o_occupancy;
  logic                          o_overflow;
  logic                          i_clearOverflow;

  result_drain_buffer #(.N(TN), .ROW_W(TW)) dut (
    .i_clk           (i_clk),
    .i_arst          (i_arst),
    .i_c             (i_c),
    .i_validResult   (i_validResult),
    .o_ready         (o_ready),
    .o_rowData       (o_rowData),
    .o_rowValid      (o_rowValid),
    .i_rowReady      (i_rowReady),
    .o_rowIdx        (o_rowIdx),
    .o_lastRow       (o_lastRow),
    .o_occupancy     (o_occupancy),
    .o_overflow      (o_overflow),
    .i_clearOverflow (i_clearOverflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int   checks   = 0;
  int   failures = 0;

  // Reference model: matrices waiting to drain, oldest first.
  mat_t model_q [$];
  int   model_row = 0;
  bit   model_ovf = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mat_t seq_mat();
    mat_t m;
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TN; c++)
        m[r][c] = TW'(r * TN + c + 1);
    return m;
  endfunction

  function automatic mat_t const_mat(input int v);
    mat_t m;
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TN; c++)
        m[r][c] = TW'(v);
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TN; c++)
        m[r][c] = $urandom;
    return m;
  endfunction

  task automatic compare_outputs();
    bit   ev;
    mat_t head;
    ev = (model_q.size() != 0);
    check("rowValid",  o_rowValid,  ev);
    check("occupancy", o_occupancy, model_q.size());
    check("ready",     o_ready,     model_q.size() < 2);
    check("overflow",  o_overflow,  model_ovf);
    if (ev) begin
      head = model_q[0];
      check("rowData", o_rowData, head[model_row]);
      check("rowIdx",  o_rowIdx,  model_row);
      check("lastRow", o_lastRow, model_row == TN - 1);
    end
  endtask

  task automatic model_step(input logic v, input mat_t m, input logic rdy, input logic clr);
    bit dropped;
    if (model_q.size() != 0 && rdy) begin
      if (model_row == TN - 1) begin
        void'(model_q.pop_front());
        model_row = 0;
      end else begin
        model_row++;
      end
    end
    dropped = v && (model_q.size() >= 2);
    if (v && !dropped) model_q.push_back(m);
    if (dropped)       model_ovf = 1'b1;
    else if (clr)      model_ovf = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare registered outputs, advance model.
  task automatic cycle(input logic v, input mat_t m, input logic rdy, input logic clr);
    i_validResult   = v;
    i_c             = m;
    i_rowReady      = rdy;
    i_clearOverflow = clr;
    compare_outputs();
    model_step(v, m, rdy, clr);
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_arst = 1'b1;
    #1;
    check("reset_rowValid",  o_rowValid,  1'b0);
    check("reset_rowIdx",    o_rowIdx,    2'd0);
    check("reset_lastRow",   o_lastRow,   1'b0);
    check("reset_occupancy", o_occupancy, 2'd0);
    check("reset_overflow",  o_overflow,  1'b0);
    check("reset_ready",     o_ready,     1'b1);
    check("reset_rowData",   o_rowData,   '0);
    model_q.delete();
    model_row = 0;
    model_ovf = 1'b0;
    @(posedge i_clk);
    #1;
    i_arst = 1'b0;
  endtask

  mat_t a_m, b_m, c_m, d_m;
  int   beats;

  initial begin
    i_arst          = 1'b1;
    i_c             = '0;
    i_validResult   = 1'b0;
    i_rowReady      = 1'b0;
    i_clearOverflow = 1'b0;
    @(posedge i_clk);
    #1;
    do_reset();

    // Single result, ready held high: four consecutive rows starting next cycle.
    cycle(1'b1, seq_mat(), 1'b1, 1'b0);
    check("single_first_row", o_rowData, {32'sd4, 32'sd3, 32'sd2, 32'sd1});
    for (int i = 0; i < 5; i++) cycle(1'b0, rand_mat(), 1'b1, 1'b0);

    // Backpressure with a 1,0,0,1 ready pattern.
    cycle(1'b1, rand_mat(), 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) cycle(1'b0, rand_mat(), (i % 4 == 0) || (i % 4 == 3), 1'b0);

    // Ping-pong: second matrix arrives while row 1 of the first drains.
    cycle(1'b1, seq_mat(), 1'b1, 1'b0);
    cycle(1'b0, rand_mat(), 1'b1, 1'b0);
    cycle(1'b1, const_mat(-7), 1'b1, 1'b0);
    beats = 2;
    for (int i = 0; i < 8; i++) begin
      if (o_rowValid) beats++;
      cycle(1'b0, rand_mat(), 1'b1, 1'b0);
    end
    check("pingpong_beats", beats, 8);

    // Overflow: third and fourth pulses dropped; set beats a same-cycle clear.
    a_m = rand_mat();
    b_m = rand_mat();
    c_m = rand_mat();
    cycle(1'b1, a_m, 1'b0, 1'b0);
    cycle(1'b1, b_m, 1'b0, 1'b0);
    cycle(1'b1, c_m, 1'b0, 1'b0);
    check("overflow_set", o_overflow, 1'b1);
    cycle(1'b1, c_m, 1'b0, 1'b1);
    check("overflow_set_beats_clear", o_overflow, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, rand_mat(), 1'b1, 1'b0);
    cycle(1'b0, rand_mat(), 1'b0, 1'b1);
    check("overflow_cleared", o_overflow, 1'b0);

    // Full buffer, final-row handshake coincides with a new pulse.
    d_m = rand_mat();
    cycle(1'b1, a_m, 1'b0, 1'b0);
    cycle(1'b1, b_m, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, rand_mat(), 1'b1, 1'b0);
    cycle(1'b1, d_m, 1'b1, 1'b0);
    check("full_final_occupancy", o_occupancy, 2'd2);
    check("full_final_overflow",  o_overflow,  1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, rand_mat(), 1'b1, 1'b0);

    // Randomized traffic, then drain to empty.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 5) == 0, rand_mat(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
    for (int i = 0; i < 20; i++) cycle(1'b0, rand_mat(), 1'b1, 1'b0);

    // Reset in the middle of a drain, after the row-1 handshake.
    cycle(1'b1, seq_mat(), 1'b1, 1'b0);
    cycle(1'b0, rand_mat(), 1'b1, 1'b0);
    cycle(1'b0, rand_mat(), 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, rand_mat(), 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
